// File: rtl/i2c_xfer_scheduler_pkg.sv
// Shared types and constants for the I2C transfer scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i2c_sched_pkg;

    // I2C 7-bit slave address and single data byte.
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    // Bridge con2 control bits.
    localparam int CON2_START_BIT = 0;
    localparam int CON2_ABORT_BIT = 1;

    // Bridge status bits.
    localparam int STAT_NACK_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ABORT = 3'd4,
        ST_RESP  = 3'd5
    } sched_state_t;

    // Bridge con1 layout: address in the upper seven bits, direction in bit 0.
    function automatic logic [7:0] mk_con1(input logic [ADDR_W-1:0] addr, input logic rnw);
        return {addr, rnw};
    endfunction

endpackage

// File: rtl/i2c_xfer_scheduler_if.sv
// Requester and bridge signal bundle for the I2C transfer scheduler.
// Latency: n/a (wiring only).
// Backpressure: requesters hold req until their done pulse; the bridge paces via br_ready.
//
// Ports:
//   req/req_rnw/req_addr/req_wdata  per-requester transfer request, fields packed per requester
//   done/rdata/err/busy             completion pulse, result byte, error flag, scheduler busy
//   br_con1/br_con2/br_din          bridge control/data registers driven by the scheduler
//   br_dout/br_ready/br_stat        bridge read data, completion, status
interface i2c_xfer_scheduler_if #(
    parameter int NREQ = 2
);
    import i2c_sched_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_rnw;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   err;
    logic                   busy;
    logic [7:0]             br_con1;
    logic [7:0]             br_con2;
    logic [31:0]            br_din;
    logic [31:0]            br_dout;
    logic                   br_ready;
    logic [7:0]             br_stat;

    // Scheduler side: it masters the bridge and serves the requesters.
    modport master (
        input  req, req_rnw, req_addr, req_wdata, br_dout, br_ready, br_stat,
        output done, rdata, err, busy, br_con1, br_con2, br_din
    );

    // Environment side: requesters plus the bridge.
    modport slave (
        output req, req_rnw, req_addr, req_wdata, br_dout, br_ready, br_stat,
        input  done, rdata, err, busy, br_con1, br_con2, br_din
    );

endinterface

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick of the first set request at or after ptr, wrapping upward.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent only samples the grant while idle and owns ptr.
//
// Ports:
//   req      pending requests, one bit per requester
//   ptr      index with highest priority this evaluation
//   gnt_vld  any request pending
//   gnt_oh   one-hot grant
//   gnt_idx  binary index of the grant
module i2c_rr_arbiter
    import i2c_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [NREQ-1:0]  gnt_oh,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        int j;
        j       = 0;
        gnt_vld = 1'b0;
        gnt_oh  = '0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Candidate i steps upward from ptr; wrap without a modulo so
            // non-power-of-two requester counts stay cheap.
            j = int'(ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!gnt_vld && req[j]) begin
                gnt_vld    = 1'b1;
                gnt_oh[j]  = 1'b1;
                gnt_idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_xfer_scheduler.sv
// Shares one I2C bridge between NREQ requesters: round-robin grant, program con1/con2/din, await ready or timeout, return result.
// Latency: request-to-done minimum 5 cycles; done lands 2 cycles after br_ready is first seen in WAIT; a timeout adds an ABORT cycle.
// Backpressure: one transfer in flight; other requesters hold req until granted, br_ready outside WAIT is ignored.
//
// Ports:
//   PCLK, PRESETn  clock and asynchronous active-low reset
//   bus            i2c_xfer_scheduler_if.master: requester fields in, done/rdata/err/busy out,
//                  bridge con1/con2/din out, dout/ready/stat in
module i2c_xfer_scheduler
    import i2c_sched_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    i2c_xfer_scheduler_if.master bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NREQ - 1);
    localparam logic [7:0]       CON2_START = 8'(1 << CON2_START_BIT);
    localparam logic [7:0]       CON2_ABORT = 8'(1 << CON2_ABORT_BIT);

    sched_state_t      state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  grant;
    logic [NREQ-1:0]   grant_oh;
    logic              rnw_q;
    logic [CNT_W-1:0]  cnt;
    logic              res_err;
    logic [DATA_W-1:0] res_rdata;

    logic [NREQ-1:0]   done_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              busy_q;
    logic [7:0]        con1_q;
    logic [7:0]        con2_q;
    logic [31:0]       din_q;

    logic              arb_vld;
    logic [NREQ-1:0]   arb_oh;
    logic [IDX_W-1:0]  arb_idx;
    logic              sel_rnw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    i2c_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .gnt_vld (arb_vld),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx)
    );

    // Fields of the requester the arbiter currently points at.
    always_comb begin
        sel_rnw   = bus.req_rnw[arb_idx];
        sel_addr  = bus.req_addr[arb_idx*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[arb_idx*DATA_W +: DATA_W];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant     <= '0;
            grant_oh  <= '0;
            rnw_q     <= 1'b0;
            cnt       <= '0;
            res_err   <= 1'b0;
            res_rdata <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            con1_q    <= '0;
            con2_q    <= '0;
            din_q     <= '0;
        end else begin
            // Completion outputs are single-cycle; RESP overrides these.
            done_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant    <= arb_idx;
                        grant_oh <= arb_oh;
                        rnw_q    <= sel_rnw;
                        // con1/din are the latched copies of addr/wdata; they are
                        // loaded on the grant edge so they are already valid
                        // throughout LOAD and stay put until RESP ends.
                        con1_q   <= mk_con1(sel_addr, sel_rnw);
                        din_q    <= {24'b0, sel_wdata};
                        busy_q   <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    con2_q <= CON2_START;
                    state  <= ST_START;
                end

                ST_START: begin
                    con2_q <= '0;
                    cnt    <= '0;
                    state  <= ST_WAIT;
                end

                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // Ready is tested first so it wins over a coincident timeout.
                    if (bus.br_ready) begin
                        res_err   <= bus.br_stat[STAT_NACK_BIT];
                        res_rdata <= rnw_q ? bus.br_dout[DATA_W-1:0] : '0;
                        state     <= ST_RESP;
                    end else if (cnt + CNT_W'(1) == CNT_LAST) begin
                        // Counter stops at TIMEOUT_CYC-1, so it cannot wrap in WAIT.
                        con2_q <= CON2_ABORT;
                        state  <= ST_ABORT;
                    end
                end

                ST_ABORT: begin
                    con2_q    <= '0;
                    res_err   <= 1'b1;
                    res_rdata <= '0;
                    state     <= ST_RESP;
                end

                ST_RESP: begin
                    done_q  <= grant_oh;
                    rdata_q <= res_rdata;
                    err_q   <= res_err;
                    ptr     <= (grant == IDX_LAST) ? '0 : grant + IDX_W'(1);
                    con1_q  <= '0;
                    din_q   <= '0;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.done    = done_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.br_con1 = con1_q;
    assign bus.br_con2 = con2_q;
    assign bus.br_din  = din_q;

    // Only dout[7:0] and stat[NACK] carry meaning for single-byte transfers.
    logic unused_bridge_bits;
    assign unused_bridge_bits = ^{bus.br_dout[31:DATA_W], bus.br_stat};

endmodule

// File: tb/tb_i2c_xfer_scheduler.sv
// Directed bench for the I2C transfer scheduler with a hand-driven bridge.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_xfer_scheduler;

    logic PCLK;
    logic PRESETn;
    int   total;
    int   bad;

    i2c_xfer_scheduler_if #(.NREQ(2)) bus ();

    i2c_xfer_scheduler #(
        .NREQ        (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // Results of the most recent serve() call.
    logic [1:0]  dn;
    logic [7:0]  rd;
    logic        er;
    int          lat;
    int          starts;
    int          aborts;
    int          abort_cyc;
    logic [7:0]  con2_ab;
    logic [7:0]  con1_first;
    logic [31:0] din_first;
    logic        busy_first;
    logic [7:0]  con1_rdy;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Called in the cycle the request is visible (cycle 0). Plays the bridge:
    // pulses br_ready 'delay' cycles after the START pulse (never if delay==0),
    // and records what the scheduler did until done is seen or 100 cycles pass.
    task automatic serve(input int delay, input bit drop, input logic [31:0] dout, input logic [7:0] stat,
                         output logic [1:0] o_dn, output logic [7:0] o_rd, output logic o_er,
                         output int o_lat, output int o_starts, output int o_aborts, output int o_abort_cyc,
                         output logic [7:0] o_con2_ab, output logic [7:0] o_con1_first,
                         output logic [31:0] o_din_first, output logic o_busy_first,
                         output logic [7:0] o_con1_rdy);
        int start_cyc;
        start_cyc    = -1;
        o_dn         = '0;
        o_rd         = '0;
        o_er         = 1'b0;
        o_lat        = -1;
        o_starts     = 0;
        o_aborts     = 0;
        o_abort_cyc  = -1;
        o_con2_ab    = '0;
        o_con1_first = '0;
        o_din_first  = '0;
        o_busy_first = 1'b0;
        o_con1_rdy   = '0;
        for (int c = 1; c <= 100 && o_lat < 0; c++) begin
            tick();
            bus.br_ready = 1'b0;
            if (c == 1) begin
                o_con1_first = bus.br_con1;
                o_din_first  = bus.br_din;
                o_busy_first = bus.busy;
                if (drop) begin
                    bus.req       = '0;
                    bus.req_rnw   = '0;
                    bus.req_addr  = '1;
                    bus.req_wdata = '1;
                end
            end
            if (bus.br_con2[0]) begin
                o_starts++;
                if (start_cyc < 0) start_cyc = c;
            end
            if (bus.br_con2[1]) begin
                o_aborts++;
                o_abort_cyc = c;
                o_con2_ab   = bus.br_con2;
            end
            if (bus.done != '0) begin
                o_dn  = bus.done;
                o_rd  = bus.rdata;
                o_er  = bus.err;
                o_lat = c;
            end else if (delay > 0 && start_cyc >= 0 && c == start_cyc + delay) begin
                bus.br_ready = 1'b1;
                bus.br_dout  = dout;
                bus.br_stat  = stat;
                o_con1_rdy   = bus.br_con1;
            end
        end
        bus.br_ready = 1'b0;
        bus.br_dout  = '0;
        bus.br_stat  = '0;
    endtask

    task automatic test_reset();
        PRESETn       = 1'b0;
        bus.req       = '0;
        bus.req_rnw   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.br_dout   = '0;
        bus.br_ready  = 1'b0;
        bus.br_stat   = '0;
        tick();
        tick();
        total++; if (bus.done !== 2'b00)   begin bad++; $display("FAIL rst_done got=%b want=00", bus.done); end
        total++; if (bus.rdata !== 8'h00)  begin bad++; $display("FAIL rst_rdata got=%h want=00", bus.rdata); end
        total++; if (bus.err !== 1'b0)     begin bad++; $display("FAIL rst_err got=%b want=0", bus.err); end
        total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.br_con1 !== 8'h00) begin bad++; $display("FAIL rst_con1 got=%h want=00", bus.br_con1); end
        total++; if (bus.br_con2 !== 8'h00) begin bad++; $display("FAIL rst_con2 got=%h want=00", bus.br_con2); end
        total++; if (bus.br_din !== 32'h0) begin bad++; $display("FAIL rst_din got=%h want=0", bus.br_din); end
        PRESETn = 1'b1;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_single_write();
        bus.req_rnw   = 2'b00;
        bus.req_addr  = {7'h00, 7'h50};
        bus.req_wdata = {8'h00, 8'hA5};
        bus.req       = 2'b01;
        serve(10, 1'b0, 32'hFFFF_FF33, 8'h00, dn, rd, er, lat, starts, aborts, abort_cyc, con2_ab,
              con1_first, din_first, busy_first, con1_rdy);
        bus.req = 2'b00;
        total++; if (con1_first !== 8'hA0)    begin bad++; $display("FAIL wr_con1 got=%h want=a0", con1_first); end
        total++; if (din_first !== 32'h000000A5) begin bad++; $display("FAIL wr_din got=%h want=000000a5", din_first); end
        total++; if (busy_first !== 1'b1)     begin bad++; $display("FAIL wr_busy got=%b want=1", busy_first); end
        total++; if (con1_rdy !== 8'hA0)      begin bad++; $display("FAIL wr_con1_hold got=%h want=a0", con1_rdy); end
        total++; if (starts !== 1)            begin bad++; $display("FAIL wr_starts got=%0d want=1", starts); end
        total++; if (aborts !== 0)            begin bad++; $display("FAIL wr_aborts got=%0d want=0", aborts); end
        total++; if (dn !== 2'b01)            begin bad++; $display("FAIL wr_done got=%b want=01", dn); end
        total++; if (er !== 1'b0)             begin bad++; $display("FAIL wr_err got=%b want=0", er); end
        total++; if (rd !== 8'h00)            begin bad++; $display("FAIL wr_rdata got=%h want=00", rd); end
        total++; if (lat !== 14)              begin bad++; $display("FAIL wr_latency got=%0d want=14", lat); end
        total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL wr_busy_at_done got=%b want=0", bus.busy); end
        tick();
        total++; if (bus.done !== 2'b00)      begin bad++; $display("FAIL wr_done_clear got=%b want=00", bus.done); end
        total++; if (bus.br_con1 !== 8'h00)   begin bad++; $display("FAIL wr_con1_clear got=%h want=00", bus.br_con1); end
        total++; if (bus.br_din !== 32'h0)    begin bad++; $display("FAIL wr_din_clear got=%h want=0", bus.br_din); end
    endtask

    // Pointer sits at 1 here. Requester 1 drops req and scrambles its fields
    // right after grant; the transfer must still complete with the latched values.
    task automatic test_single_read();
        bus.req_rnw   = 2'b10;
        bus.req_addr  = {7'h3C, 7'h00};
        bus.req_wdata = {8'hFF, 8'h00};
        bus.req       = 2'b10;
        serve(1, 1'b1, 32'hDEAD_005A, 8'hFE, dn, rd, er, lat, starts, aborts, abort_cyc, con2_ab,
              con1_first, din_first, busy_first, con1_rdy);
        bus.req = 2'b00;
        total++; if (con1_first !== 8'h79)    begin bad++; $display("FAIL rd_con1 got=%h want=79", con1_first); end
        total++; if (din_first !== 32'h000000FF) begin bad++; $display("FAIL rd_din got=%h want=000000ff", din_first); end
        total++; if (con1_rdy !== 8'h79)      begin bad++; $display("FAIL rd_con1_latched got=%h want=79", con1_rdy); end
        total++; if (dn !== 2'b10)            begin bad++; $display("FAIL rd_done got=%b want=10", dn); end
        total++; if (rd !== 8'h5A)            begin bad++; $display("FAIL rd_rdata got=%h want=5a", rd); end
        total++; if (er !== 1'b0)             begin bad++; $display("FAIL rd_err got=%b want=0", er); end
        total++; if (lat !== 5)               begin bad++; $display("FAIL rd_min_latency got=%0d want=5", lat); end
    endtask

    task automatic test_nack();
        bus.req_rnw   = 2'b00;
        bus.req_addr  = {7'h00, 7'h2A};
        bus.req_wdata = {8'h00, 8'h11};
        bus.req       = 2'b01;
        serve(3, 1'b0, 32'h0000_00AB, 8'h01, dn, rd, er, lat, starts, aborts, abort_cyc, con2_ab,
              con1_first, din_first, busy_first, con1_rdy);
        bus.req = 2'b00;
        total++; if (con1_first !== 8'h54) begin bad++; $display("FAIL nack_con1 got=%h want=54", con1_first); end
        total++; if (dn !== 2'b01)         begin bad++; $display("FAIL nack_done got=%b want=01", dn); end
        total++; if (er !== 1'b1)          begin bad++; $display("FAIL nack_err got=%b want=1", er); end
        total++; if (rd !== 8'h00)         begin bad++; $display("FAIL nack_rdata got=%h want=00", rd); end
        total++; if (lat !== 7)            begin bad++; $display("FAIL nack_latency got=%0d want=7", lat); end
    endtask

    // From reset with both requesters held high: grants go 0,1,0,1.
    task automatic test_contention();
        logic [1:0] exp_dn;
        logic [7:0] exp_c1;
        logic [7:0] exp_rd;
        PRESETn = 1'b0;
        tick();
        PRESETn       = 1'b1;
        bus.req_rnw   = 2'b01;
        bus.req_addr  = {7'h22, 7'h11};
        bus.req_wdata = {8'h5C, 8'h00};
        bus.req       = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve(2 + k, 1'b0, 32'h0000_0040 + k, 8'h00, dn, rd, er, lat, starts, aborts, abort_cyc, con2_ab,
                  con1_first, din_first, busy_first, con1_rdy);
            exp_dn = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_c1 = (k % 2 == 0) ? 8'h23 : 8'h44;
            exp_rd = (k % 2 == 0) ? 8'(8'h40 + k) : 8'h00;
            total++; if (dn !== exp_dn)         begin bad++; $display("FAIL cont_grant%0d got=%b want=%b", k, dn, exp_dn); end
            total++; if (con1_first !== exp_c1) begin bad++; $display("FAIL cont_con1_%0d got=%h want=%h", k, con1_first, exp_c1); end
            total++; if (rd !== exp_rd)         begin bad++; $display("FAIL cont_rdata%0d got=%h want=%h", k, rd, exp_rd); end
            total++; if (lat !== 6 + k)         begin bad++; $display("FAIL cont_latency%0d got=%0d want=%0d", k, lat, 6 + k); end
        end
        bus.req = 2'b00;
    endtask

    task automatic test_timeout();
        // No ready at all: ABORT 16 cycles after START (cycle 2), done two cycles later.
        bus.req_rnw   = 2'b00;
        bus.req_addr  = {7'h08, 7'h08};
        bus.req_wdata = {8'h03, 8'h03};
        bus.req       = 2'b10;
        serve(0, 1'b0, 32'h0, 8'h00, dn, rd, er, lat, starts, aborts, abort_cyc, con2_ab,
              con1_first, din_first, busy_first, con1_rdy);
        bus.req = 2'b00;
        total++; if (starts !== 1)      begin bad++; $display("FAIL to_starts got=%0d want=1", starts); end
        total++; if (aborts !== 1)      begin bad++; $display("FAIL to_abort_width got=%0d want=1", aborts); end
        total++; if (abort_cyc !== 18)  begin bad++; $display("FAIL to_abort_cycle got=%0d want=18", abort_cyc); end
        total++; if (con2_ab !== 8'h02) begin bad++; $display("FAIL to_con2 got=%h want=02", con2_ab); end
        total++; if (dn !== 2'b10)      begin bad++; $display("FAIL to_done got=%b want=10", dn); end
        total++; if (er !== 1'b1)       begin bad++; $display("FAIL to_err got=%b want=1", er); end
        total++; if (rd !== 8'h00)      begin bad++; $display("FAIL to_rdata got=%h want=00", rd); end
        total++; if (lat !== 20)        begin bad++; $display("FAIL to_latency got=%0d want=20", lat); end

        // Ready on the last WAIT cycle, coinciding with the timeout: ready wins.
        bus.req_rnw = 2'b01;
        bus.req     = 2'b01;
        serve(15, 1'b0, 32'h0000_0066, 8'h00, dn, rd, er, lat, starts, aborts, abort_cyc, con2_ab,
              con1_first, din_first, busy_first, con1_rdy);
        bus.req = 2'b00;
        total++; if (aborts !== 0)   begin bad++; $display("FAIL edge_aborts got=%0d want=0", aborts); end
        total++; if (dn !== 2'b01)   begin bad++; $display("FAIL edge_done got=%b want=01", dn); end
        total++; if (er !== 1'b0)    begin bad++; $display("FAIL edge_err got=%b want=0", er); end
        total++; if (rd !== 8'h66)   begin bad++; $display("FAIL edge_rdata got=%h want=66", rd); end
        total++; if (lat !== 19)     begin bad++; $display("FAIL edge_latency got=%0d want=19", lat); end

        // Ready one cycle too late lands in ABORT and is ignored.
        bus.req_rnw = 2'b00;
        bus.req     = 2'b10;
        serve(16, 1'b0, 32'h0000_0077, 8'h00, dn, rd, er, lat, starts, aborts, abort_cyc, con2_ab,
              con1_first, din_first, busy_first, con1_rdy);
        bus.req = 2'b00;
        total++; if (aborts !== 1)   begin bad++; $display("FAIL late_aborts got=%0d want=1", aborts); end
        total++; if (dn !== 2'b10)   begin bad++; $display("FAIL late_done got=%b want=10", dn); end
        total++; if (er !== 1'b1)    begin bad++; $display("FAIL late_err got=%b want=1", er); end
        total++; if (lat !== 20)     begin bad++; $display("FAIL late_latency got=%0d want=20", lat); end
    endtask

    task automatic test_reset_mid_wait();
        int done_seen;
        // Move the pointer to 1.
        bus.req_rnw   = 2'b00;
        bus.req_addr  = {7'h30, 7'h10};
        bus.req_wdata = {8'h22, 8'h11};
        bus.req       = 2'b01;
        serve(1, 1'b0, 32'h0, 8'h00, dn, rd, er, lat, starts, aborts, abort_cyc, con2_ab,
              con1_first, din_first, busy_first, con1_rdy);
        total++; if (dn !== 2'b01) begin bad++; $display("FAIL mid_pre_done got=%b want=01", dn); end
        // Requester 1 gets to WAIT (cycles 3 and 4), then reset lands mid-cycle.
        bus.req = 2'b10;
        for (int c = 0; c < 4; c++) tick();
        total++; if (bus.busy !== 1'b1)    begin bad++; $display("FAIL mid_busy_before got=%b want=1", bus.busy); end
        #2;
        PRESETn = 1'b0;
        #1;
        total++; if (bus.br_con1 !== 8'h00) begin bad++; $display("FAIL mid_con1 got=%h want=00", bus.br_con1); end
        total++; if (bus.br_din !== 32'h0)  begin bad++; $display("FAIL mid_din got=%h want=0", bus.br_din); end
        total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
        total++; if (bus.br_con2 !== 8'h00) begin bad++; $display("FAIL mid_con2 got=%h want=00", bus.br_con2); end
        done_seen = 0;
        bus.br_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.done != '0 || bus.br_con2 != '0) done_seen++;
        end
        bus.br_ready = 1'b0;
        total++; if (done_seen !== 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", done_seen); end
        PRESETn = 1'b1;
        bus.req = 2'b11;
        serve(1, 1'b0, 32'h0, 8'h00, dn, rd, er, lat, starts, aborts, abort_cyc, con2_ab,
              con1_first, din_first, busy_first, con1_rdy);
        total++; if (dn !== 2'b01) begin bad++; $display("FAIL mid_after_first got=%b want=01", dn); end
        total++; if (lat !== 5)    begin bad++; $display("FAIL mid_after_latency got=%0d want=5", lat); end
        bus.req = 2'b10;
        serve(1, 1'b0, 32'h0, 8'h00, dn, rd, er, lat, starts, aborts, abort_cyc, con2_ab,
              con1_first, din_first, busy_first, con1_rdy);
        bus.req = 2'b00;
        total++; if (dn !== 2'b10) begin bad++; $display("FAIL mid_after_second got=%b want=10", dn); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_write();
        test_single_read();
        test_nack();
        test_contention();
        test_timeout();
        test_reset_mid_wait();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
